ram_arbiter: RTL

- Shares the single-port 512x32 RAM between two requesters: port 0 is the CPU memory subsystem (MAR/MDR path) and port 1 is the loader/debug requester.
- Each port uses a req/done handshake with a latched address and latched write data.
- Grants are round-robin.
- A three-phase state machine sequences the RAM's Read/Write strobes and returns read data with a fixed latency.

---
 rtl/ram_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two req/done ports.
// IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> DONE; read data returned on done.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned       CNT_W    = 2;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time takes the grant.
          owner_d = (req0 && req1) ? ~last_q : req1;
          last_d  = owner_d;
          we_d    = owner_d ? we1    : we0;
          addr_d  = owner_d ? addr1  : addr0;
          wdata_d = owner_d ? wdata1 : wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q) rdata1_d = ram_rdata;
            else         rdata0_d = ram_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    gnt       = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    done0     = (state_q == DONE) && !owner_q;
    done1     = (state_q == DONE) &&  owner_q;
    ram_read  = (state_q == ISSUE) && !we_q;
    ram_write = (state_q == ISSUE) &&  we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    rdata0    = rdata0_q;
    rdata1    = rdata1_q;
  end

endmodule
